// File: rtl/dense_pkg.sv
// dense_pkg: shared FSM encodings and fp32 field constants for the dense classifier stages
package dense_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t DONE = 2'd2;
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB = 30;
    localparam int FP32_EXP_LSB = 23;
    localparam int FP32_MANT_MSB = 22;
    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
endpackage

// File: rtl/fp32_gt.sv
// fp32_gt: combinational strict a > b on fp32 bit patterns, NaN never wins, +0 equals -0
module fp32_gt
    import dense_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);
    logic a_nan, b_nan, both_zero, mag_gt, mag_lt, a_neg, b_neg;
    assign a_nan = (a[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_MAX) && (|a[FP32_MANT_MSB:0]);
    assign b_nan = (b[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_MAX) && (|b[FP32_MANT_MSB:0]);
    assign both_zero = ~|{a[FP32_SIGN_BIT-1:0], b[FP32_SIGN_BIT-1:0]};
    assign mag_gt = a[FP32_SIGN_BIT-1:0] > b[FP32_SIGN_BIT-1:0];
    assign mag_lt = a[FP32_SIGN_BIT-1:0] < b[FP32_SIGN_BIT-1:0];
    assign a_neg = a[FP32_SIGN_BIT];
    assign b_neg = b[FP32_SIGN_BIT];
    // sign-magnitude order; a real number always displaces a NaN incumbent
    always_comb gt = !a_nan && (b_nan || (!both_zero && ((a_neg != b_neg) ? !a_neg : (a_neg ? mag_lt : mag_gt))));
endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: captures a dense output vector and scans it serially for the arg-max class
module dense_argmax
    import dense_pkg::*;
#(
    parameter int NUMS = 128,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH = $clog2(NUMS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic [NUMS*DATA_WIDTH-1:0] data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [IDX_WIDTH-1:0]       class_o,
    output logic [DATA_WIDTH-1:0]      max_o
);
    localparam int CW = IDX_WIDTH + 1;
    localparam logic [CW-1:0] END = CW'(NUMS);
    state_t state;
    logic [CW-1:0] idx;
    logic [NUMS*DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] elem [NUMS];
    logic [DATA_WIDTH-1:0] cand, best_val;
    logic [IDX_WIDTH-1:0] best_idx;
    logic gt;
    logic load;
    for (genvar g = 0; g < NUMS; g++) begin : g_elem
        assign elem[g] = buf_q[g*DATA_WIDTH +: DATA_WIDTH];
    end
    assign cand = elem[idx[IDX_WIDTH-1:0]];
    assign load = (state == IDLE) && valid_i;
    fp32_gt u_gt (
        .a  (cand),
        .b  (best_val),
        .gt (gt)
    );
    // vector buffer: written only when a new vector is accepted, so it is stable during the scan
    always_ff @(posedge clk) begin
        if (load) buf_q <= data_i;
    end
    // scan FSM; idx runs one past the last element so the result appears NUMS edges after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            best_val <= '0;
            best_idx <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            class_o  <= '0;
            max_o    <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    state    <= SCAN;
                    idx      <= CW'(1);
                    best_val <= data_i[DATA_WIDTH-1:0];
                    best_idx <= '0;
                    ready_o  <= 1'b0;
                end
                SCAN: if (idx == END) begin
                    state   <= DONE;
                    valid_o <= 1'b1;
                    class_o <= best_idx;
                    max_o   <= best_val;
                end else begin
                    idx <= idx + CW'(1);
                    if (gt) begin
                        best_val <= cand;
                        best_idx <= idx[IDX_WIDTH-1:0];
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_dense_argmax;
    localparam int N = 128;
    typedef struct {
        logic [6:0]  c;
        logic [31:0] m;
        int          at;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    logic valid_i = 0;
    logic [N*32-1:0] data_i = '0;
    logic ready_o, valid_o;
    logic [6:0] class_o;
    logic [31:0] max_o;
    logic [N*32-1:0] v, v2;
    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit chk_next = 0;

    dense_argmax dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .class_o (class_o),
        .max_o   (max_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] fp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic fill(input logic [31:0] x);
        for (int i = 0; i < N; i++) v[i*32 +: 32] = x;
    endtask

    task automatic ramp();
        for (int i = 0; i < N; i++) v[i*32 +: 32] = fp(1.5 + 0.03 * i);
    endtask

    task automatic send(input logic [6:0] c, input logic [31:0] m, input bit expect_it);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, ready_o}, 32'd1);
        data_i = v;
        valid_i = 1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 0;
        if (expect_it) begin
            e.c = c;
            e.m = m;
            e.at = cyc + N;
            q.push_back(e);
        end
    endtask

    task automatic reset_vals(input string nm);
        chk({nm, "_ready"}, {31'd0, ready_o}, 32'd1);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({nm, "_class"}, {25'd0, class_o}, 32'd0);
        chk({nm, "_max"}, max_o, 32'd0);
    endtask

    // monitor: every valid_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (chk_next) begin
            chk("pulse_end_valid", {31'd0, valid_o}, 32'd0);
            chk("pulse_end_ready", {31'd0, ready_o}, 32'd1);
        end
        chk_next = 0;
        if (valid_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got class %0d max %h expected no pulse", class_o, max_o);
            end else begin
                e = q.pop_front();
                chk("class", {25'd0, class_o}, {25'd0, e.c});
                chk("max", max_o, e.m);
                chk("latency_cycle", cyc, e.at);
                chk("ready_in_done", {31'd0, ready_o}, 32'd0);
                chk_next = 1;
            end
        end
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        reset_vals("reset");
        rst = 0;

        ramp();
        send(7'd127, v[127*32 +: 32], 1);

        for (int i = 0; i < N; i++) v[i*32 +: 32] = fp(-1.0 - i);
        send(7'd0, 32'hBF800000, 1);

        fill(32'h00000000);
        v[5*32 +: 32] = 32'h40E00000;
        v[9*32 +: 32] = 32'h40E00000;
        send(7'd5, 32'h40E00000, 1);

        fill(32'hBF800000);
        v[0 +: 32] = 32'h80000000;
        v[32 +: 32] = 32'h00000000;
        send(7'd0, 32'h80000000, 1);

        fill(32'hC0400000);
        v[0 +: 32] = 32'h7FC00000;
        v[3*32 +: 32] = 32'h7F800001;
        v[10*32 +: 32] = 32'h40000000;
        send(7'd10, 32'h40000000, 1);

        fill(32'h7FC00000);
        send(7'd0, 32'h7FC00000, 1);

        fill(32'hFF800000);
        v[30*32 +: 32] = 32'h00000001;
        v[77*32 +: 32] = 32'h7F800000;
        v[100*32 +: 32] = 32'h7F7FFFFF;
        send(7'd77, 32'h7F800000, 1);

        ramp();
        send(7'd127, v[127*32 +: 32], 1);
        repeat (19) @(negedge clk);
        for (int i = 0; i < N; i++) v2[i*32 +: 32] = 32'h42C80000;
        data_i = v2;
        valid_i = 1;
        @(negedge clk);
        valid_i = 0;

        ramp();
        send(7'd0, 32'd0, 0);
        repeat (39) @(negedge clk);
        rst = 1;
        @(negedge clk);
        reset_vals("mid_reset");
        repeat (3) @(negedge clk);
        reset_vals("reset_hold");
        rst = 0;
        repeat (N + 5) @(negedge clk);
        chk("after_abort_class", {25'd0, class_o}, 32'd0);

        ramp();
        send(7'd127, v[127*32 +: 32], 1);

        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
